fetch_unit: RTL

Instruction fetch stage directly upstream of the Core datapath/control pair. It owns the fetch PC and issues in-order word requests to instruction memory. Returned words are buffered in a small FIFO and handed to decode over a valid/ready interface. A branch/jump redirect from the datapath flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 30 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between fetch_unit and its neighbours: instruction memory,
// the datapath redirect and decode.
interface fetch_unit_if;
   // Every channel is valid/ready: a transfer happens on a rising edge where
   // valid and ready are both high. The imem response channel has no ready;
   // a word is accepted in every cycle where imem_resp_valid is high.
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
             redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order word requests, DEPTH-entry instruction FIFO and redirect flush.
// Define FETCH_BYPASS_EN to hand a response to decode in its arrival cycle when the FIFO is empty.
module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc, resp_pc, redirect_tgt;
   logic [CW-1:0] outstanding, outstanding_nxt, drop, count;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem [DEPTH];
   logic          req_fire, resp_ok, resp_keep, bypass, push, pop;

   assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

   // Buffered plus in-flight words never exceed DEPTH, so the FIFO can always absorb every response.
   assign bus.imem_req_valid = (({1'b0, count} + {1'b0, outstanding}) < DEPTH_C)
                               && !bus.redirect_valid && !reset;
   assign bus.imem_req_addr  = fetch_pc;

   assign req_fire        = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_ok         = bus.imem_resp_valid && (outstanding != '0);
   assign resp_keep       = resp_ok && (drop == '0) && !bus.redirect_valid;
   assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(resp_ok);

`ifdef FETCH_BYPASS_EN
   assign bypass = resp_keep && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign bus.inst_valid = (count != '0) || bypass;

   always_comb begin
      bus.inst_data = '0;
      bus.inst_pc   = '0;
      if (count != '0) begin
         bus.inst_data = data_mem[rd_ptr];
         bus.inst_pc   = pc_mem[rd_ptr];
      end else if (bypass) begin
         bus.inst_data = bus.imem_resp_data;
         bus.inst_pc   = resp_pc;
      end
   end

   assign pop  = (count != '0) && bus.inst_ready;
   assign push = resp_keep && !(bypass && bus.inst_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc <= redirect_tgt;
            resp_pc  <= redirect_tgt;
            drop     <= outstanding_nxt;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (resp_ok && (drop != '0))
               drop <= drop - CW'(1);
            if (resp_keep)
               resp_pc <= resp_pc + 32'd4;
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= bus.imem_resp_data;
         pc_mem[wr_ptr]   <= resp_pc;
      end
   end

   resp_without_request: assert property (@(posedge clk) disable iff (reset)
      bus.imem_resp_valid |-> (outstanding != '0));
   occupancy_bound: assert property (@(posedge clk) disable iff (reset)
      ({1'b0, count} + {1'b0, outstanding}) <= DEPTH_C);
   drop_bound: assert property (@(posedge clk) disable iff (reset)
      drop <= outstanding);
endmodule
